// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and widths for the counter tracker
package counter_pkg;

  localparam int CNT_W      = 4;
  localparam int DEF_STAT_W = 8;

  // Tracking state: no sample yet, direction unknown, locked up, locked down
  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    ACQ     = 2'd1,
    LOCK_UP = 2'd2,
    LOCK_DN = 2'd3
  } state_e;

  // Relation of a new sample to the previous one, modulo 16
  typedef enum logic [1:0] {
    UP   = 2'd0,
    DN   = 2'd1,
    HOLD = 2'd2,
    JUMP = 2'd3
  } step_e;

endpackage

// File: rtl/count_tracker_4bit_step_classify.sv
// rtl/count_tracker_4bit_step_classify.sv - classifies one sample step against the previous
module step_classify
  import counter_pkg::*;
(
  input  logic [CNT_W-1:0] p,
  input  logic [CNT_W-1:0] s,
  output step_e            cls,
  output logic             wrap
);

  logic [CNT_W-1:0] delta;

  // Modular difference picks the step class; a wrap is a unit step across the 15/0 seam
  always_comb begin
    delta = s - p;
    if (delta == 4'd1) begin
      cls = UP;
    end else if (delta == 4'd15) begin
      cls = DN;
    end else if (delta == 4'd0) begin
      cls = HOLD;
    end else begin
      cls = JUMP;
    end
    wrap = ((cls == UP) && (p == 4'd15)) || ((cls == DN) && (p == 4'd0));
  end

endmodule

// File: rtl/count_tracker_4bit.sv
// rtl/count_tracker_4bit.sv - tracks direction and events of an observed up/down counter
module count_tracker_4bit
  import counter_pkg::*;
#(
  parameter int STAT_W = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [CNT_W-1:0]  cn_in,
  output logic [CNT_W-1:0]  last,
  output logic              locked,
  output logic              dir,
  output logic              hold_p,
  output logic              wrap_p,
  output logic              turn_p,
  output logic              jump_p,
  output logic [STAT_W-1:0] wrap_cnt,
  output logic [STAT_W-1:0] jump_cnt
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  last_q;
  logic              dir_q, dir_d;
  logic              hold_q, wrap_q, turn_q, jump_q;
  logic              hold_d, wrap_d, turn_d, jump_d;
  logic [STAT_W-1:0] wrap_cnt_q, jump_cnt_q;
  step_e             cls;
  logic              wrap_flag;

  step_classify u_classify (
    .p    (last_q),
    .s    (cn_in),
    .cls  (cls),
    .wrap (wrap_flag)
  );

  // State register; reset discards all history
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= UNSYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: direction is learned from unit steps and lost on a jump
  always_comb begin
    state_d = state_q;
    if (valid) begin
      unique case (state_q)
        UNSYNC:  state_d = ACQ;
        ACQ: begin
          if (cls == UP)      state_d = LOCK_UP;
          else if (cls == DN) state_d = LOCK_DN;
        end
        LOCK_UP: begin
          if (cls == DN)        state_d = LOCK_DN;
          else if (cls == JUMP) state_d = ACQ;
        end
        LOCK_DN: begin
          if (cls == UP)        state_d = LOCK_UP;
          else if (cls == JUMP) state_d = ACQ;
        end
        default: state_d = UNSYNC;
      endcase
    end
  end

  // Event decode: the first sample has no predecessor, so it never raises a pulse
  always_comb begin
    hold_d = 1'b0;
    wrap_d = 1'b0;
    turn_d = 1'b0;
    jump_d = 1'b0;
    dir_d  = dir_q;
    if (valid && (state_q != UNSYNC)) begin
      hold_d = (cls == HOLD);
      wrap_d = wrap_flag;
      turn_d = ((state_q == LOCK_UP) && (cls == DN)) ||
               ((state_q == LOCK_DN) && (cls == UP));
      jump_d = ((state_q == LOCK_UP) || (state_q == LOCK_DN)) && (cls == JUMP);
    end
    if (state_d == LOCK_UP)      dir_d = 1'b1;
    else if (state_d == LOCK_DN) dir_d = 1'b0;
  end

  // Registered sample, direction, single-cycle pulses and saturating statistics
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q     <= '0;
      dir_q      <= 1'b0;
      hold_q     <= 1'b0;
      wrap_q     <= 1'b0;
      turn_q     <= 1'b0;
      jump_q     <= 1'b0;
      wrap_cnt_q <= '0;
      jump_cnt_q <= '0;
    end else begin
      hold_q <= hold_d;
      wrap_q <= wrap_d;
      turn_q <= turn_d;
      jump_q <= jump_d;
      dir_q  <= dir_d;
      if (valid) begin
        last_q <= cn_in;
      end
      if (wrap_d && (wrap_cnt_q != {STAT_W{1'b1}})) begin
        wrap_cnt_q <= wrap_cnt_q + 1'b1;
      end
      if (jump_d && (jump_cnt_q != {STAT_W{1'b1}})) begin
        jump_cnt_q <= jump_cnt_q + 1'b1;
      end
    end
  end

  assign last     = last_q;
  assign locked   = (state_q == LOCK_UP) || (state_q == LOCK_DN);
  assign dir      = dir_q;
  assign hold_p   = hold_q;
  assign wrap_p   = wrap_q;
  assign turn_p   = turn_q;
  assign jump_p   = jump_q;
  assign wrap_cnt = wrap_cnt_q;
  assign jump_cnt = jump_cnt_q;

endmodule

// File: tb/tb_count_tracker_4bit.sv
// tb/tb_count_tracker_4bit.sv - randomized self-checking bench with a behavioural model
module tb_count_tracker_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] cn_in = 4'd0;
  logic [3:0] last;
  logic       locked, dir, hold_p, wrap_p, turn_p, jump_p;
  logic [7:0] wrap_cnt, jump_cnt;

  int n_chk = 0;
  int n_bad = 0;

  count_tracker_4bit #(.STAT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .cn_in    (cn_in),
    .last     (last),
    .locked   (locked),
    .dir      (dir),
    .hold_p   (hold_p),
    .wrap_p   (wrap_p),
    .turn_p   (turn_p),
    .jump_p   (jump_p),
    .wrap_cnt (wrap_cnt),
    .jump_cnt (jump_cnt)
  );

  always #5 clk = ~clk;

  // Model: have_prev / known direction / direction value, stepped with modular arithmetic
  bit       m_have;
  bit       m_known;
  bit       m_dir;
  int       m_prev;
  bit       m_hold, m_wrap, m_turn, m_jump;
  int       m_wcnt, m_jcnt;

  logic [25:0] got;
  assign got = {last, locked, dir, hold_p, wrap_p, turn_p, jump_p, wrap_cnt, jump_cnt};

  function automatic logic [25:0] exp_vec();
    logic [3:0] p4;
    logic [7:0] w8, j8;
    p4 = m_prev[3:0];
    w8 = m_wcnt[7:0];
    j8 = m_jcnt[7:0];
    return {p4, m_known, m_dir, m_hold, m_wrap, m_turn, m_jump, w8, j8};
  endfunction

  task automatic model_step(input bit r, input bit v, input int s);
    int d;
    m_hold = 0; m_wrap = 0; m_turn = 0; m_jump = 0;
    if (!r) begin
      m_have = 0; m_known = 0; m_dir = 0; m_prev = 0; m_wcnt = 0; m_jcnt = 0;
    end else if (v) begin
      if (m_have) begin
        d = (s - m_prev + 16) % 16;
        m_hold = (d == 0);
        m_wrap = (d == 1 && m_prev == 15) || (d == 15 && m_prev == 0);
        if (d == 1 || d == 15) begin
          if (m_known && (m_dir != (d == 1))) m_turn = 1;
          m_known = 1;
          m_dir = (d == 1);
        end else if (d != 0 && m_known) begin
          m_jump = 1;
          m_known = 0;
        end
        if (m_wrap && m_wcnt < 255) m_wcnt++;
        if (m_jump && m_jcnt < 255) m_jcnt++;
      end
      m_have = 1;
      m_prev = s;
    end
  endtask

  // Apply one cycle of inputs; the model advances with the clock edge, outputs settle 1ns later
  task automatic tick(input bit r, input bit v, input int s);
    rst = r;
    valid = v;
    cn_in = s[3:0];
    @(posedge clk);
    model_step(r, v, s);
    #1;
  endtask

  task automatic test_reset();
    tick(0, 1, 9);
    tick(0, 1, 3);
    n_chk++;
    if (got !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_zero got=%h exp=%h", got, 26'd0);
    end
    n_chk++;
    if (got !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_model got=%h exp=%h", got, exp_vec());
    end
  endtask

  task automatic test_lock_up();
    int seq [3] = '{3, 4, 5};
    tick(0, 0, 0);
    foreach (seq[i]) begin
      tick(1, 1, seq[i]);
      n_chk++;
      if (got !== exp_vec()) begin
        n_bad++;
        $display("FAIL lock_up_step%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    n_chk++;
    if ({last, locked, dir, hold_p, wrap_p, turn_p, jump_p} !== {4'd5, 6'b110000}) begin
      n_bad++;
      $display("FAIL lock_up_final got=%h exp=%h",
               {last, locked, dir, hold_p, wrap_p, turn_p, jump_p}, {4'd5, 6'b110000});
    end
  endtask

  task automatic test_wrap();
    int seq [6] = '{12, 13, 14, 15, 0, 1};
    int wraps = 0;
    tick(0, 0, 0);
    foreach (seq[i]) begin
      tick(1, 1, seq[i]);
      if (wrap_p) wraps++;
      n_chk++;
      if (got !== exp_vec()) begin
        n_bad++;
        $display("FAIL wrap_step%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    n_chk++;
    if (wraps != 1 || wrap_cnt !== 8'd1 || locked !== 1'b1 || dir !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_final got=wraps%0d cnt%0d lk%b dir%b exp=wraps1 cnt1 lk1 dir1",
               wraps, wrap_cnt, locked, dir);
    end
  endtask

  task automatic test_turn_hold();
    tick(0, 0, 0);
    tick(1, 1, 5);
    tick(1, 1, 6);
    tick(1, 1, 5);
    n_chk++;
    if ({locked, dir, hold_p, wrap_p, turn_p, jump_p} !== 6'b100010 || got !== exp_vec()) begin
      n_bad++;
      $display("FAIL turn got=%h exp=%h", got, exp_vec());
    end
    tick(1, 1, 5);
    n_chk++;
    if ({locked, dir, hold_p, wrap_p, turn_p, jump_p} !== 6'b101000 || got !== exp_vec()) begin
      n_bad++;
      $display("FAIL hold got=%h exp=%h", got, exp_vec());
    end
  endtask

  task automatic test_jump();
    tick(0, 0, 0);
    tick(1, 1, 6);
    tick(1, 1, 7);
    tick(1, 1, 4);
    n_chk++;
    if (jump_p !== 1'b1 || jump_cnt !== 8'd1 || locked !== 1'b0 || got !== exp_vec()) begin
      n_bad++;
      $display("FAIL jump got=%h exp=%h", got, exp_vec());
    end
    tick(1, 1, 5);
    n_chk++;
    if (locked !== 1'b1 || dir !== 1'b1 || jump_p !== 1'b0 || jump_cnt !== 8'd1
        || got !== exp_vec()) begin
      n_bad++;
      $display("FAIL jump_relock got=%h exp=%h", got, exp_vec());
    end
  endtask

  task automatic test_saturation();
    tick(0, 0, 0);
    tick(1, 1, 15);
    for (int i = 0; i < 259; i++) begin
      tick(1, 1, (i % 2 == 0) ? 0 : 15);
      n_chk++;
      if (got !== exp_vec() || wrap_p !== 1'b1) begin
        n_bad++;
        $display("FAIL sat_step%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    n_chk++;
    if (wrap_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL sat_final got=%0d exp=255", wrap_cnt);
    end
  endtask

  task automatic test_reset_mid();
    tick(0, 0, 0);
    tick(1, 1, 10);
    tick(1, 1, 9);
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, $urandom_range(0, 15));
      n_chk++;
      if (got !== exp_vec() || last !== 4'd9 || locked !== 1'b1 || dir !== 1'b0) begin
        n_bad++;
        $display("FAIL gap%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    tick(0, 1, 8);
    n_chk++;
    if (got !== 26'd0 || got !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_mid got=%h exp=%h", got, 26'd0);
    end
  endtask

  task automatic test_random();
    int s;
    tick(0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: s = (m_prev + 1) % 16;
        1: s = (m_prev + 15) % 16;
        2: s = m_prev;
        default: s = $urandom_range(0, 15);
      endcase
      tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), s);
      n_chk++;
      if (got !== exp_vec()) begin
        n_bad++;
        $display("FAIL random%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_wrap();
    test_turn_hold();
    test_jump();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
